systolic_allocator: RTL

Per-core scheduler that shares the core's `NUM_SYSTOLIC_ARRAYS` systolic arrays among its `THREADS_PER_BLOCK` threads. Threads raise level requests. The allocator picks one requester per cycle using round-robin order and binds it to the lowest-index free array. It then starts that array, tracks ownership, and routes the array's completion back to the owning thread before freeing the array. It sits in `core` between the per-thread execution logic and the systolic array cluster.

---
 rtl/systolic_allocator_pkg.sv | 9 +
 rtl/systolic_allocator_if.sv | 32 +++
 rtl/systolic_allocator_rr_arbiter.sv | 28 ++
 rtl/systolic_allocator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/systolic_allocator_pkg.sv
// Shared scheduler types and defaults for the GPU core schedulers.
package gpu_sched_pkg;

   localparam int NUM_ARRAYS_DEFAULT     = 8;
   localparam int NUM_REQUESTERS_DEFAULT = 4;

   typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT, REQ_RUN} req_state_t;

endpackage

// File: rtl/systolic_allocator_if.sv
// Thread-request / array-control bundle between core threads, the allocator and the array cluster.
interface systolic_allocator_if
   import gpu_sched_pkg::*;
#(
   parameter int NUM_REQUESTERS = NUM_REQUESTERS_DEFAULT,
   parameter int NUM_ARRAYS     = NUM_ARRAYS_DEFAULT
);
   localparam int ID_BITS = $clog2(NUM_ARRAYS);

   logic [NUM_REQUESTERS-1:0]              req_valid;
   logic [NUM_REQUESTERS-1:0]              grant;
   logic [NUM_REQUESTERS-1:0][ID_BITS-1:0] grant_array_id;
   logic [NUM_REQUESTERS-1:0]              req_done;
   logic [NUM_ARRAYS-1:0]                  array_start;
   logic [NUM_ARRAYS-1:0]                  array_done;
   logic [NUM_ARRAYS-1:0]                  array_busy;
   logic [ID_BITS:0]                       busy_count;
   logic                                   protocol_error;

   modport master (
      output req_valid, array_done,
      input  grant, grant_array_id, req_done, array_start, array_busy,
             busy_count, protocol_error
   );

   modport slave (
      input  req_valid, array_done,
      output grant, grant_array_id, req_done, array_start, array_busy,
             busy_count, protocol_error
   );

endinterface

// File: rtl/systolic_allocator_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_grant,
   output logic [$clog2(N)-1:0] o_idx,
   output logic                 o_valid
);

   always_comb begin
      int k;
      k       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = (int'(i_ptr) + i) % N;
         if (!o_valid && i_req[k]) begin
            o_valid    = 1'b1;
            o_idx      = ($clog2(N))'(k);
            o_grant[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/systolic_allocator.sv
// Shares the core's systolic arrays among its threads: one round-robin grant per cycle,
// lowest free array, ownership tracking and completion routing back to the owning thread.
//
//   state    | meaning
//   REQ_IDLE | no request outstanding
//   REQ_WAIT | requesting, not yet granted
//   REQ_RUN  | owns an array, waiting for its completion
module systolic_allocator
   import gpu_sched_pkg::*;
#(
   parameter int NUM_REQUESTERS = NUM_REQUESTERS_DEFAULT,
   parameter int NUM_ARRAYS     = NUM_ARRAYS_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   systolic_allocator_if.slave bus
);

   localparam int ID_BITS  = $clog2(NUM_ARRAYS);
   localparam int PTR_BITS = $clog2(NUM_REQUESTERS);

   req_state_t r_state      [NUM_REQUESTERS];
   req_state_t w_state_next [NUM_REQUESTERS];

   logic [PTR_BITS-1:0]                    r_rr_ptr;
   logic [PTR_BITS-1:0]                    r_owner [NUM_ARRAYS];
   logic [NUM_ARRAYS-1:0]                  r_array_busy;
   logic [NUM_ARRAYS-1:0]                  r_array_start;
   logic [NUM_REQUESTERS-1:0]              r_grant;
   logic [NUM_REQUESTERS-1:0]              r_req_done;
   logic [NUM_REQUESTERS-1:0][ID_BITS-1:0] r_grant_id;
   logic [ID_BITS:0]                       r_busy_count;
   logic                                   r_protocol_error;

   logic [NUM_REQUESTERS-1:0] w_eligible;
   logic [NUM_REQUESTERS-1:0] w_rr_grant;
   logic [PTR_BITS-1:0]       w_rr_idx;
   logic                      w_rr_valid;
   logic                      w_free_valid;
   logic [ID_BITS-1:0]        w_free_idx;
   logic [NUM_ARRAYS-1:0]     w_free_onehot;
   logic                      w_do_grant;
   logic [NUM_ARRAYS-1:0]     w_done_hit;
   logic                      w_done_err;
   logic [NUM_REQUESTERS-1:0] w_req_done_next;
   logic [NUM_ARRAYS-1:0]     w_busy_next;
   logic [ID_BITS:0]          w_busy_count_next;

   always_comb begin
      w_eligible = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++)
         w_eligible[k] = bus.req_valid[k] && (r_state[k] != REQ_RUN);
   end

   rr_arbiter #(.N(NUM_REQUESTERS)) u_rr_arbiter (
      .i_req   (w_eligible),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx),
      .o_valid (w_rr_valid)
   );

   // Uses the busy map from before this cycle's completions, so a just-freed array is never reused.
   always_comb begin
      w_free_valid  = 1'b0;
      w_free_idx    = '0;
      w_free_onehot = '0;
      for (int a = NUM_ARRAYS - 1; a >= 0; a--) begin
         if (!r_array_busy[a]) begin
            w_free_valid = 1'b1;
            w_free_idx   = ID_BITS'(a);
         end
      end
      if (w_free_valid)
         w_free_onehot[w_free_idx] = 1'b1;
   end

   assign w_do_grant = w_rr_valid && w_free_valid;
   assign w_done_hit = bus.array_done & r_array_busy;
   assign w_done_err = |(bus.array_done & ~r_array_busy);

   always_comb begin
      w_req_done_next = '0;
      for (int a = 0; a < NUM_ARRAYS; a++)
         if (w_done_hit[a])
            w_req_done_next[r_owner[a]] = 1'b1;
   end

   always_comb begin
      w_busy_next       = (r_array_busy & ~w_done_hit) | (w_do_grant ? w_free_onehot : '0);
      w_busy_count_next = '0;
      for (int a = 0; a < NUM_ARRAYS; a++)
         w_busy_count_next = w_busy_count_next + (ID_BITS+1)'(w_busy_next[a]);
   end

   always_comb begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         w_state_next[k] = r_state[k];
         case (r_state[k])
            REQ_IDLE, REQ_WAIT: begin
               if (w_do_grant && w_rr_grant[k])
                  w_state_next[k] = REQ_RUN;
               else if (bus.req_valid[k])
                  w_state_next[k] = REQ_WAIT;
               else
                  w_state_next[k] = REQ_IDLE;
            end
            REQ_RUN: begin
               if (w_req_done_next[k])
                  w_state_next[k] = REQ_IDLE;
            end
            default: w_state_next[k] = REQ_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         if (reset)
            r_state[k] <= REQ_IDLE;
         else
            r_state[k] <= w_state_next[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr         <= '0;
         r_array_busy     <= '0;
         r_array_start    <= '0;
         r_grant          <= '0;
         r_req_done       <= '0;
         r_grant_id       <= '0;
         r_busy_count     <= '0;
         r_protocol_error <= 1'b0;
         for (int a = 0; a < NUM_ARRAYS; a++)
            r_owner[a] <= '0;
      end else begin
         r_array_busy  <= w_busy_next;
         r_busy_count  <= w_busy_count_next;
         r_req_done    <= w_req_done_next;
         r_grant       <= w_do_grant ? w_rr_grant : '0;
         r_array_start <= w_do_grant ? w_free_onehot : '0;
         if (w_do_grant) begin
            r_owner[w_free_idx]  <= w_rr_idx;
            r_grant_id[w_rr_idx] <= w_free_idx;
            if (int'(w_rr_idx) == NUM_REQUESTERS - 1)
               r_rr_ptr <= '0;
            else
               r_rr_ptr <= w_rr_idx + 1'b1;
         end
         if (w_done_err)
            r_protocol_error <= 1'b1;
      end
   end

   assign bus.grant          = r_grant;
   assign bus.grant_array_id = r_grant_id;
   assign bus.req_done       = r_req_done;
   assign bus.array_start    = r_array_start;
   assign bus.array_busy     = r_array_busy;
   assign bus.busy_count     = r_busy_count;
   assign bus.protocol_error = r_protocol_error;

endmodule
